// File: rtl/fir_pkg.sv
// Shared definitions for the decimating FIR sequencer.
//   SAMPLE_W : width of input samples and of the MAC data input
//   COEF_W   : width of the coefficient ROM word feeding the MAC
//   state_t  : sequencer state encoding (CLR, IDLE, RUN)
package fir_pkg;

  localparam int SAMPLE_W = 18;
  localparam int COEF_W   = 25;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer, 2^AW words of DW bits.
// The write port and the read port are independent. Reads are registered,
// so data appears one clock after the read is issued. The memory contents
// are not reset; only the read data register is.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset of the read data register
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata holds its value when low
//   raddr : read address
//   rdata : registered read data
module sample_ram #(
  parameter int AW = 7,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its output when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DW{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequencer driving a multiply-accumulate unit as a decimating FIR filter.
// Incoming samples land in a circular buffer. Every DECIM accepted samples,
// the newest NTAPS samples are streamed newest first to the MAC, one per
// clock, with a matching coefficient ROM address and first/last tags.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   din   : input sample (two's complement)
//   dv    : single-cycle valid strobe for din
//   caddr : coefficient ROM address (ROM has a 1-clock registered read)
//   mdin  : sample to the MAC data input
//   first : tags tap 0 of a run
//   last  : tags tap NTAPS-1 of a run
//   busy  : high while clearing the buffer or running
//   ovr   : sticky overrun flag, cleared only by rst
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int NTAPS = 64,
  parameter int AW    = 7,
  parameter int DECIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                dv,
  output logic [AW-1:0]       caddr,
  output logic [SAMPLE_W-1:0] mdin,
  output logic                first,
  output logic                last,
  output logic                busy,
  output logic                ovr
);

  localparam logic [AW-1:0] K_LAST    = AW'(NTAPS - 1);
  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    D_LAST    = 8'(DECIM - 1);

  state_t              state_r;
  state_t              state_nx_s;
  logic [AW-1:0]       wptr_r;
  logic [AW-1:0]       base_r;
  logic [AW-1:0]       k_r;
  logic [7:0]          dcnt_r;
  logic                first_r;
  logic                last_r;
  logic                busy_r;
  logic                ovr_r;

  logic                acc_s;
  logic                start_s;
  logic                we_s;
  logic [SAMPLE_W-1:0] wd_s;
  logic                re_s;
  logic [AW-1:0]       raddr_s;

  // Sample acceptance, start request and buffer write mux.
  always_comb begin
    acc_s = 1'b0;
    we_s  = 1'b0;
    wd_s  = {SAMPLE_W{1'b0}};
    case (state_r)
      CLR: begin
        we_s = 1'b1;
      end
      IDLE, RUN: begin
        acc_s = dv;
        we_s  = dv;
        wd_s  = din;
      end
      default: begin
        acc_s = 1'b0;
      end
    endcase
    start_s = acc_s && (dcnt_r == D_LAST);
    re_s    = (state_r == RUN);
    // Taps walk backwards from the newest sample, wrapping mod 2^AW.
    raddr_s = base_r - k_r;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      CLR: begin
        if (wptr_r == ADDR_LAST) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLR;
        end
      end
      IDLE: begin
        if (start_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (k_r == K_LAST) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = CLR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLR;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Write pointer: sweeps the whole buffer in CLR, then advances per sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= ADDR_ZERO;
    end else if ((state_r == CLR) || acc_s) begin
      wptr_r <= wptr_r + ADDR_ONE;
    end
  end

  // Decimation counter over accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_r <= 8'd0;
    end else if (acc_s) begin
      if (dcnt_r == D_LAST) begin
        dcnt_r <= 8'd0;
      end else begin
        dcnt_r <= dcnt_r + 8'd1;
      end
    end
  end

  // Run base (address of the sample that triggered the run) and tap index.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= ADDR_ZERO;
      k_r    <= ADDR_ZERO;
    end else if ((state_r == IDLE) && start_s) begin
      base_r <= wptr_r;
      k_r    <= ADDR_ZERO;
    end else if (state_r == RUN) begin
      if (k_r == K_LAST) begin
        k_r <= ADDR_ZERO;
      end else begin
        k_r <= k_r + ADDR_ONE;
      end
    end
  end

  // Sticky overrun: samples dropped while clearing, or a start while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_r <= 1'b0;
    end else if ((dv && (state_r == CLR)) || (start_s && (state_r == RUN))) begin
      ovr_r <= 1'b1;
    end
  end

  // Tags registered in step with the RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      first_r <= (state_r == RUN) && (k_r == ADDR_ZERO);
      last_r  <= (state_r == RUN) && (k_r == K_LAST);
    end
  end

  // Busy follows the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b1;
    end else begin
      busy_r <= (state_nx_s != IDLE);
    end
  end

  sample_ram #(
    .AW (AW),
    .DW (SAMPLE_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (wptr_r),
    .wdata (wd_s),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (mdin)
  );

  assign caddr = k_r;
  assign first = first_r;
  assign last  = last_r;
  assign busy  = busy_r;
  assign ovr   = ovr_r;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq with a transaction-level reference model.
module tb_fir_mac_seq;

  localparam int NTAPS = 64;
  localparam int AW    = 7;
  localparam int DECIM = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic [17:0]   din;
  logic [AW-1:0] caddr;
  logic [17:0]   mdin;
  logic          first;
  logic          last;
  logic          busy;
  logic          ovr;

  always #5 clk = ~clk;

  fir_mac_seq #(.NTAPS(NTAPS), .AW(AW), .DECIM(DECIM)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .dv    (dv),
    .caddr (caddr),
    .mdin  (mdin),
    .first (first),
    .last  (last),
    .busy  (busy),
    .ovr   (ovr)
  );

  int total = 0;
  int bad   = 0;
  int p     = 0;

  // reference model state
  logic [17:0] mm [DEPTH];
  int          wptr_m;
  int          dcnt_m;
  bit          ovr_m;
  int          clr_end   = 0;
  int          run_start = -1;
  int          run_end   = -1;
  bit          chk_on    = 0;
  logic [17:0] cur_md    = 18'd0;
  logic [17:0] exp_md [int];
  bit          exp_f  [int];
  bit          exp_l  [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s period=%0d got=%0h exp=%0h", tag, p, got, exp);
    end
  endtask

  // One clock period: check outputs, then apply this period's inputs to DUT and model.
  task automatic cyc(input bit r, input bit v, input logic [17:0] d);
    int base;
    @(negedge clk);
    p++;
    if (chk_on) begin
      if (exp_md.exists(p)) cur_md = exp_md[p];
      chk("mdin",  mdin,  cur_md);
      chk("first", first, exp_f.exists(p) ? 1 : 0);
      chk("last",  last,  exp_l.exists(p) ? 1 : 0);
      chk("busy",  busy,  ((p <= clr_end) || (p <= run_end)) ? 1 : 0);
      chk("ovr",   ovr,   ovr_m);
      if ((run_start >= 0) && (p > run_start) && (p <= run_end))
        chk("caddr", caddr, p - run_start - 1);
      else if (p <= clr_end)
        chk("caddr_clr", caddr, 0);
    end
    rst = r;
    dv  = v;
    din = d;
    if (r) begin
      clr_end   = p + DEPTH;
      run_start = -1;
      run_end   = -1;
      for (int i = 0; i < DEPTH; i++) mm[i] = 18'd0;
      wptr_m = 0;
      dcnt_m = 0;
      ovr_m  = 0;
      for (int q = p + 1; q <= p + NTAPS + 3; q++) begin
        if (exp_md.exists(q)) exp_md.delete(q);
        if (exp_f.exists(q))  exp_f.delete(q);
        if (exp_l.exists(q))  exp_l.delete(q);
      end
      exp_md[p + 1] = 18'd0;
      chk_on = 1;
    end else if (v) begin
      if (p <= clr_end) begin
        ovr_m = 1;
      end else begin
        mm[wptr_m] = d;
        base   = wptr_m;
        wptr_m = (wptr_m + 1) % DEPTH;
        dcnt_m++;
        if (dcnt_m == DECIM) begin
          dcnt_m = 0;
          if (p <= run_end) begin
            ovr_m = 1;
          end else begin
            run_start = p;
            run_end   = p + NTAPS;
            for (int k = 0; k < NTAPS; k++)
              exp_md[p + 2 + k] = mm[(base - k) & (DEPTH - 1)];
            exp_f[p + 2]         = 1;
            exp_l[p + NTAPS + 1] = 1;
          end
        end
      end
    end
  endtask

  task automatic send(input logic [17:0] d, input int gap);
    cyc(1'b0, 1'b1, d);
    repeat (gap - 1) cyc(1'b0, 1'b0, 18'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 18'd0);
  endtask

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    din = 18'd0;

    // reset, zero-fill, then impulse runs
    repeat (3) cyc(1'b1, 1'b0, 18'd0);
    idle(140);
    send(18'd1000, 80);
    repeat (3) send(18'd0, 80);
    repeat (8) send(18'($urandom()), 80);

    // ramp across the buffer wrap
    for (int i = 1; i <= 200; i++) send(18'(i), 17);
    idle(80);

    // samples too fast: overrun
    repeat (8) send(18'($urandom()), 10);
    repeat (12) send(18'($urandom()), $urandom_range(2, 12));
    idle(100);

    // reset in the middle of a run (k=30)
    cyc(1'b1, 1'b0, 18'd0);
    idle(135);
    repeat (3) send(18'($urandom()), 5);
    cyc(1'b0, 1'b1, 18'($urandom()));
    idle(30);
    cyc(1'b1, 1'b0, 18'd0);
    idle(140);
    repeat (8) send(18'($urandom()), 17);
    idle(80);

    // samples arriving during the buffer clear are dropped
    cyc(1'b1, 1'b0, 18'd0);
    idle(20);
    repeat (3) send(18'($urandom()), 30);
    cyc(1'b0, 1'b1, 18'h3ffff);
    idle(50);
    repeat (12) send(18'($urandom()), $urandom_range(17, 25));
    idle(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
